pkt_output_mux: RTL and testbench
=================================

Name: pkt_output_mux

Overview:
Parametrised, registered, packet-aware N:1 output multiplexer for the switch output port. It sits between the per-input queues and the output link, downstream of the output arbiter. When the arbiter grants an input, the block locks onto that input for a whole packet. It moves beats with a valid/ready handshake and buffers them in a 2-entry output stage, so it tolerates downstream backpressure without losing data.

Parameters:
NUM_PORTS, 4, number of input channels (2..16)
DATA_W, 16, beat data width in bits
SEL_W, $clog2(NUM_PORTS), width of the select and lock index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
arb_active  input  1  arbiter has a winner this cycle
mux_sel  input  SEL_W  winning input index from the arbiter
data_in  input  NUM_PORTS*DATA_W  flattened input data, input i at bits [i*DATA_W +: DATA_W]
valid_in  input  NUM_PORTS  per-input beat valid
last_in  input  NUM_PORTS  per-input end-of-packet flag, qualified by valid_in
ready_out  output  NUM_PORTS  per-input accept, one-hot or zero
data_out  output  DATA_W  output beat data
valid_out  output  1  output beat valid
last_out  output  1  output end-of-packet flag
ready_in  input  1  downstream accepts the beat
busy  output  1  block is locked to an input (state LOCKED)
cur_sel  output  SEL_W  locked input index
pkt_done  output  1  one-cycle pulse, cycle after the last beat of a packet is accepted at the input

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, cur_sel=0, buffer count=0, valid_out=0, data_out=0, last_out=0, busy=0, pkt_done=0, ready_out=0.
- State machine, IDLE:
  - If arb_active=1 and mux_sel<NUM_PORTS: cur_sel<=mux_sel and state<=LOCKED on the next edge.
  - If mux_sel>=NUM_PORTS: the request is ignored and the block stays IDLE.
  - ready_out=0 throughout.
- State machine, LOCKED:
  - busy=1. arb_active and mux_sel are ignored.
  - ready_out[cur_sel]=(count<2). All other ready_out bits are 0.
  - ready_out depends only on registered state, never on ready_in or valid_in.
- Input accept: a beat is accepted when valid_in[cur_sel]&&ready_out[cur_sel]. Data and last are pushed into the output buffer.
- Packet end: an accepted beat with last_in[cur_sel]=1 sends state to IDLE on the next edge, and pkt_done pulses 1 for that cycle.
  - A new grant can be latched in the cycle the block is back in IDLE.
  - Minimum gap between packets: 1 idle cycle.
- Output buffer: 2-entry FIFO (head register plus skid register), count 0..2.
  - valid_out=(count>0). data_out and last_out come from the head entry.
  - When valid_out=0, data_out and last_out are forced to 0.
- Output pop: occurs when valid_out&&ready_in.
  - Simultaneous push and pop leave count unchanged and preserve order.
  - While valid_out=1 and ready_in=0, data_out and last_out are held stable.
- Latency and throughput:
  - Accepted beat appears on valid_out the next cycle when the buffer was empty.
  - Full throughput is one beat per cycle with ready_in=1.
- Backpressure: when count=2, ready_out drops. No beat is ever dropped or duplicated.
- Single-beat packet (valid and last on the first beat): accepted normally, returns to IDLE.
- Reset mid-packet: all state clears immediately. Buffered beats are discarded and outputs return to their reset values.

Test Plan:
- Basic path: grant input 2 (arb_active=1, mux_sel=2). Send a 3-beat packet 0xA001, 0xA002, 0xA003 (last on beat 3), ready_in=1. Required: busy from the next cycle, ready_out=4'b0100, the three beats on data_out on consecutive cycles each one cycle after accept, last_out only on 0xA003, pkt_done one pulse, then IDLE.
- Lock hold: during a packet from input 1, toggle mux_sel=3 with arb_active=1. Required: cur_sel stays 1, ready_out[3] stays 0, no input-3 data appears.
- Backpressure: hold ready_in=0 while input 0 sends 0x1111, 0x2222, 0x3333. Required: ready_out[0] drops after two accepts, data_out held at 0x1111. After ready_in=1, output is 0x1111, 0x2222, 0x3333 in order with no loss.
- Back-to-back packets: 1-beat packet on input 3, then immediate grant to input 0. Required: one idle cycle between packets, pkt_done pulses twice, last_out asserted on each packet's final beat.
- Reset mid-packet: assert rst_n=0 after 2 beats of a 4-beat packet. Required: valid_out, busy and ready_out are 0 immediately, data_out=0, state IDLE after release.
- Out of range: with NUM_PORTS=3, arb_active=1 and mux_sel=3. Required: stays IDLE, busy=0.

Source files
------------

// File: rtl/pkt_output_mux.sv
// Packet-aware N:1 output mux: locks to the granted input for a whole
// packet and buffers beats in a 2-entry head/skid stage.
// Ports: clk, rst_n; arb_active/mux_sel grant; data_in/valid_in/last_in
// and ready_out per input; data_out/valid_out/last_out/ready_in output
// link; busy/cur_sel lock status; pkt_done end-of-packet pulse.
module pkt_output_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 16,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        arb_active,
  input  logic [SEL_W-1:0]            mux_sel,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic [NUM_PORTS-1:0]        valid_in,
  input  logic [NUM_PORTS-1:0]        last_in,
  output logic [NUM_PORTS-1:0]        ready_out,
  output logic [DATA_W-1:0]           data_out,
  output logic                        valid_out,
  output logic                        last_out,
  input  logic                        ready_in,
  output logic                        busy,
  output logic [SEL_W-1:0]            cur_sel,
  output logic                        pkt_done
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W:0] NP = (SEL_W+1)'(NUM_PORTS);

  state_t            state;
  logic [1:0]        count;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] skid_data;
  logic              head_last;
  logic              skid_last;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              full;
  logic              push;
  logic              pop;
  logic              in_range;

  assign full     = (count == 2'd2);
  assign in_range = ({1'b0, mux_sel} < NP);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    ready_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cur_sel == SEL_W'(i)) begin
        sel_valid    = valid_in[i];
        sel_last     = last_in[i];
        sel_data     = data_in[i*DATA_W +: DATA_W];
        ready_out[i] = (state == LOCKED) && !full;
      end
    end
  end

  assign push      = (state == LOCKED) && !full && sel_valid;
  assign valid_out = (count != 2'd0);
  assign pop       = valid_out && ready_in;
  assign data_out  = valid_out ? head_data : '0;
  assign last_out  = valid_out ? head_last : 1'b0;
  assign busy      = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_sel  <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= push && sel_last;
      unique case (state)
        IDLE: begin
          if (arb_active && in_range) begin
            cur_sel <= mux_sel;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (push && sel_last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head always holds the oldest beat; skid holds the second when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= sel_data;
            head_last <= sel_last;
          end else begin
            skid_data <= sel_data;
            skid_last <= sel_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= skid_data;
          head_last <= skid_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_data <= sel_data;
            head_last <= sel_last;
          end else begin
            head_data <= skid_data;
            head_last <= skid_last;
            skid_data <= sel_data;
            skid_last <= sel_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_output_mux.sv
// Directed bench for pkt_output_mux: 4-port main instance plus a 3-port
// instance for the out-of-range grant case.
module tb_pkt_output_mux;

  logic        clk;
  logic        rst_n;
  logic        arb_active;
  logic [1:0]  mux_sel;
  logic [63:0] data_in;
  logic [3:0]  valid_in;
  logic [3:0]  last_in;
  logic [3:0]  ready_out;
  logic [15:0] data_out;
  logic        valid_out;
  logic        last_out;
  logic        ready_in;
  logic        busy;
  logic [1:0]  cur_sel;
  logic        pkt_done;

  logic        arb3;
  logic [1:0]  sel3;
  logic [47:0] din3;
  logic [2:0]  vin3;
  logic [2:0]  lin3;
  logic [2:0]  rdy3;
  logic [15:0] dout3;
  logic        vout3;
  logic        lout3;
  logic        busy3;
  logic [1:0]  cur3;
  logic        done3;

  int checks = 0;
  int errors = 0;

  pkt_output_mux #(.NUM_PORTS(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .arb_active(arb_active), .mux_sel(mux_sel),
    .data_in(data_in), .valid_in(valid_in), .last_in(last_in),
    .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out),
    .last_out(last_out), .ready_in(ready_in), .busy(busy),
    .cur_sel(cur_sel), .pkt_done(pkt_done)
  );

  pkt_output_mux #(.NUM_PORTS(3), .DATA_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .arb_active(arb3), .mux_sel(sel3),
    .data_in(din3), .valid_in(vin3), .last_in(lin3),
    .ready_out(rdy3), .data_out(dout3), .valid_out(vout3),
    .last_out(lout3), .ready_in(1'b1), .busy(busy3),
    .cur_sel(cur3), .pkt_done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    arb_active = 1'b0;
    mux_sel    = 2'd0;
    data_in    = '0;
    valid_in   = '0;
    last_in    = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ready_in = 1'b1;
    arb3 = 1'b0; sel3 = 2'd0; din3 = '0; vin3 = '0; lin3 = '0;
    repeat (2) @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (ready_out !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", ready_out); end
    checks++; if (data_out !== 16'h0 || last_out !== 1'b0) begin errors++; $display("FAIL rst_data got %h/%b exp 0000/0", data_out, last_out); end
    checks++; if (pkt_done !== 1'b0 || cur_sel !== 2'd0) begin errors++; $display("FAIL rst_misc got %b/%0d exp 0/0", pkt_done, cur_sel); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    ready_in = 1'b1;
    arb_active = 1'b1; mux_sel = 2'd2;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || cur_sel !== 2'd2) begin errors++; $display("FAIL basic_lock got %b/%0d exp 1/2", busy, cur_sel); end
    checks++; if (ready_out !== 4'b0100) begin errors++; $display("FAIL basic_ready got %b exp 0100", ready_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", valid_out); end
    arb_active = 1'b0;
    valid_in = 4'b0100; data_in[47:32] = 16'hA001;
    @(negedge clk);
    checks++; if (valid_out !== 1'b1 || data_out !== 16'hA001 || last_out !== 1'b0) begin errors++; $display("FAIL basic_b1 got %b/%h/%b exp 1/a001/0", valid_out, data_out, last_out); end
    data_in[47:32] = 16'hA002;
    @(negedge clk);
    checks++; if (data_out !== 16'hA002 || last_out !== 1'b0) begin errors++; $display("FAIL basic_b2 got %h/%b exp a002/0", data_out, last_out); end
    data_in[47:32] = 16'hA003; last_in = 4'b0100;
    @(negedge clk);
    checks++; if (data_out !== 16'hA003 || last_out !== 1'b1) begin errors++; $display("FAIL basic_b3 got %h/%b exp a003/1", data_out, last_out); end
    checks++; if (pkt_done !== 1'b1 || busy !== 1'b0 || ready_out !== 4'b0) begin errors++; $display("FAIL basic_end got %b/%b/%b exp 1/0/0000", pkt_done, busy, ready_out); end
    idle_inputs();
    @(negedge clk);
    checks++; if (valid_out !== 1'b0 || pkt_done !== 1'b0 || data_out !== 16'h0) begin errors++; $display("FAIL basic_drain got %b/%b/%h exp 0/0/0000", valid_out, pkt_done, data_out); end
  endtask

  task automatic test_lock_hold();
    ready_in = 1'b1;
    arb_active = 1'b1; mux_sel = 2'd1;
    @(negedge clk);
    checks++; if (cur_sel !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL lock_grant got %0d/%b exp 1/1", cur_sel, busy); end
    mux_sel = 2'd3;
    valid_in = 4'b1010;
    data_in[63:48] = 16'hDEAD; data_in[31:16] = 16'h0B01;
    @(negedge clk);
    checks++; if (cur_sel !== 2'd1 || ready_out !== 4'b0010) begin errors++; $display("FAIL lock_hold got %0d/%b exp 1/0010", cur_sel, ready_out); end
    checks++; if (data_out !== 16'h0B01) begin errors++; $display("FAIL lock_d1 got %h exp 0b01", data_out); end
    data_in[31:16] = 16'h0B02; last_in = 4'b1010;
    @(negedge clk);
    checks++; if (data_out !== 16'h0B02 || last_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL lock_d2 got %h/%b/%b exp 0b02/1/0", data_out, last_out, busy); end
    idle_inputs();
    @(negedge clk);
    checks++; if (valid_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lock_done got %b/%b exp 0/0", valid_out, busy); end
  endtask

  task automatic test_backpressure();
    ready_in = 1'b0;
    arb_active = 1'b1; mux_sel = 2'd0;
    @(negedge clk);
    arb_active = 1'b0;
    valid_in = 4'b0001; data_in[15:0] = 16'h1111;
    @(negedge clk);
    checks++; if (ready_out !== 4'b0001 || data_out !== 16'h1111) begin errors++; $display("FAIL bp_one got %b/%h exp 0001/1111", ready_out, data_out); end
    data_in[15:0] = 16'h2222;
    @(negedge clk);
    checks++; if (ready_out !== 4'b0000 || data_out !== 16'h1111 || valid_out !== 1'b1) begin errors++; $display("FAIL bp_full got %b/%h/%b exp 0000/1111/1", ready_out, data_out, valid_out); end
    data_in[15:0] = 16'h3333; last_in = 4'b0001;
    @(negedge clk);
    checks++; if (data_out !== 16'h1111 || ready_out !== 4'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold got %h/%b/%b exp 1111/0000/1", data_out, ready_out, busy); end
    ready_in = 1'b1;
    @(negedge clk);
    checks++; if (data_out !== 16'h2222 || ready_out !== 4'b0001) begin errors++; $display("FAIL bp_d2 got %h/%b exp 2222/0001", data_out, ready_out); end
    @(negedge clk);
    checks++; if (data_out !== 16'h3333 || last_out !== 1'b1 || pkt_done !== 1'b1) begin errors++; $display("FAIL bp_d3 got %h/%b/%b exp 3333/1/1", data_out, last_out, pkt_done); end
    idle_inputs();
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    ready_in = 1'b1;
    arb_active = 1'b1; mux_sel = 2'd3;
    @(negedge clk);
    arb_active = 1'b0;
    valid_in = 4'b1000; last_in = 4'b1000; data_in[63:48] = 16'hC001;
    @(negedge clk);
    done_cnt += int'(pkt_done);
    checks++; if (busy !== 1'b0 || data_out !== 16'hC001 || last_out !== 1'b1) begin errors++; $display("FAIL b2b_p1 got %b/%h/%b exp 0/c001/1", busy, data_out, last_out); end
    valid_in = 4'b0000; last_in = 4'b0000;
    arb_active = 1'b1; mux_sel = 2'd0;
    @(negedge clk);
    done_cnt += int'(pkt_done);
    checks++; if (busy !== 1'b1 || cur_sel !== 2'd0 || valid_out !== 1'b0) begin errors++; $display("FAIL b2b_lock got %b/%0d/%b exp 1/0/0", busy, cur_sel, valid_out); end
    arb_active = 1'b0;
    valid_in = 4'b0001; data_in[15:0] = 16'hD001;
    @(negedge clk);
    done_cnt += int'(pkt_done);
    checks++; if (data_out !== 16'hD001 || last_out !== 1'b0) begin errors++; $display("FAIL b2b_d1 got %h/%b exp d001/0", data_out, last_out); end
    data_in[15:0] = 16'hD002; last_in = 4'b0001;
    @(negedge clk);
    done_cnt += int'(pkt_done);
    checks++; if (data_out !== 16'hD002 || last_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_d2 got %h/%b/%b exp d002/1/0", data_out, last_out, busy); end
    idle_inputs();
    @(negedge clk);
    done_cnt += int'(pkt_done);
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d exp 2", done_cnt); end
  endtask

  task automatic test_reset_mid();
    ready_in = 1'b0;
    arb_active = 1'b1; mux_sel = 2'd1;
    @(negedge clk);
    arb_active = 1'b0;
    valid_in = 4'b0010; data_in[31:16] = 16'hE001;
    @(negedge clk);
    data_in[31:16] = 16'hE002;
    @(negedge clk);
    checks++; if (valid_out !== 1'b1 || data_out !== 16'hE001) begin errors++; $display("FAIL rm_pre got %b/%h exp 1/e001", valid_out, data_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0 || busy !== 1'b0 || ready_out !== 4'b0) begin errors++; $display("FAIL rm_async got %b/%b/%b exp 0/0/0000", valid_out, busy, ready_out); end
    checks++; if (data_out !== 16'h0 || last_out !== 1'b0) begin errors++; $display("FAIL rm_data got %h/%b exp 0000/0", data_out, last_out); end
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid_out !== 1'b0 || ready_out !== 4'b0) begin errors++; $display("FAIL rm_after got %b/%b/%b exp 0/0/0000", busy, valid_out, ready_out); end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    arb3 = 1'b1; sel3 = 2'd3;
    repeat (2) @(negedge clk);
    checks++; if (busy3 !== 1'b0 || rdy3 !== 3'b000) begin errors++; $display("FAIL oor_idle got %b/%b exp 0/000", busy3, rdy3); end
    sel3 = 2'd2;
    @(negedge clk);
    checks++; if (busy3 !== 1'b1 || cur3 !== 2'd2 || rdy3 !== 3'b100) begin errors++; $display("FAIL oor_valid got %b/%0d/%b exp 1/2/100", busy3, cur3, rdy3); end
    arb3 = 1'b0;
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_basic();
    test_lock_hold();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
